// File: rtl/note_display_pkg.sv
// Shared constants for the note history queue and the per-note renderer.
// Screen coordinate widths and box geometry live here so both sides agree.
package note_display_pkg;

    localparam int NOTE_WIDTH = 6;
    localparam int BOX_W      = 32;
    localparam int BOX_H      = 8;
    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int CNT_W      = 5;

endpackage

// File: rtl/note_history_lookup.sv
// Combinational pixel-to-row lookup for the note history list.
// Maps a scanned pixel to a row index and box top, given the slide offset.
module note_history_lookup
    import note_display_pkg::*;
#(
    parameter int             DEPTH     = 8,
    parameter logic [X_W-1:0] X_BASE    = 11'd400,
    parameter logic [Y_W-1:0] Y_BASE    = 10'd64,
    parameter int             ROW_SHIFT = 4,
    localparam int            AW        = ROW_SHIFT + 1,
    localparam int            IDX_W     = $clog2(DEPTH)
) (
    input  logic [X_W-1:0]   x_i,
    input  logic [Y_W-1:0]   y_i,
    input  logic [AW-1:0]    a_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [Y_W-1:0]   y1_o
);

    logic [11:0]    sum;
    logic [11:0]    rel12;
    logic [X_W-1:0] rel;
    logic [X_W-1:0] idx_full;
    logic [11:0]    xe;
    logic           rel_ok;
    logic           row_ok;
    logic           x_ok;

    // sum never exceeds 1039, so bit 11 of the difference is the sign
    assign sum      = {2'b00, y_i} + 12'(a_i);
    assign rel12    = sum - 12'(Y_BASE);
    assign rel_ok   = ~rel12[11];
    assign rel      = rel12[X_W-1:0];
    assign idx_full = rel >> ROW_SHIFT;
    assign row_ok   = idx_full < X_W'(count_i);

    assign xe   = {1'b0, x_i};
    assign x_ok = (xe >= 12'(X_BASE)) &&
                  (xe < 12'(X_BASE) + 12'(BOX_W));

    assign hit_o = x_ok && rel_ok && row_ok;
    assign idx_o = idx_full[IDX_W-1:0];
    assign y1_o  = Y_BASE + Y_W'(idx_full << ROW_SHIFT) - Y_W'(a_i);

endmodule

// File: rtl/note_history_queue.sv
// Recent-note list with frame-synchronous commits and a sliding animation.
// Produces box origin, note code and valid per scanned pixel, 1 cycle late.
module note_history_queue
    import note_display_pkg::*;
#(
    parameter int             DEPTH     = 8,
    parameter logic [X_W-1:0] X_BASE    = 11'd400,
    parameter logic [Y_W-1:0] Y_BASE    = 10'd64,
    parameter int             ROW_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  note_in_valid,
    input  logic [NOTE_WIDTH-1:0] note_in,
    input  logic                  clear,
    input  logic                  frame_tick,
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    output logic [X_W-1:0]        x_out,
    output logic [Y_W-1:0]        y_out,
    output logic [X_W-1:0]        x1_out,
    output logic [Y_W-1:0]        y1_out,
    output logic [NOTE_WIDTH-1:0] note_out,
    output logic                  valid_out,
    output logic [CNT_W-1:0]      count,
    output logic                  dropped
);

    localparam int AW    = ROW_SHIFT + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [NOTE_WIDTH-1:0] entry_q [DEPTH];
    logic [NOTE_WIDTH-1:0] entry_d [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [AW-1:0]         a_q, a_d;
    logic                  pend_v_q, pend_v_d;
    logic [NOTE_WIDTH-1:0] pend_note_q, pend_note_d;
    logic                  drop_q, drop_d;

    logic [X_W-1:0]        x_q, x1_q;
    logic [Y_W-1:0]        y_q, y1_q;
    logic [NOTE_WIDTH-1:0] note_q;
    logic                  valid_q;

    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic [Y_W-1:0]        y1;

    always_comb begin
        entry_d     = entry_q;
        count_d     = count_q;
        a_d         = a_q;
        pend_v_d    = pend_v_q;
        pend_note_d = pend_note_q;
        drop_d      = 1'b0;
        if (clear) begin
            count_d  = '0;
            pend_v_d = 1'b0;
            a_d      = '0;
        end else begin
            if (frame_tick) begin
                if (pend_v_q) begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        entry_d[i] = entry_q[i-1];
                    end
                    entry_d[0] = pend_note_q;
                    count_d    = (count_q == CNT_W'(DEPTH)) ?
                                 count_q : count_q + CNT_W'(1);
                    pend_v_d   = 1'b0;
                    a_d        = AW'(1 << ROW_SHIFT);
                end else if (a_q != '0) begin
                    a_d = a_q - AW'(1);
                end
            end
            // a note committed by this same tick is not lost
            if (note_in_valid) begin
                pend_note_d = note_in;
                pend_v_d    = 1'b1;
                drop_d      = pend_v_q && !frame_tick;
            end
        end
    end

    note_history_lookup #(
        .DEPTH     (DEPTH),
        .X_BASE    (X_BASE),
        .Y_BASE    (Y_BASE),
        .ROW_SHIFT (ROW_SHIFT)
    ) u_lookup (
        .x_i     (x),
        .y_i     (y),
        .a_i     (a_q),
        .count_i (count_q),
        .hit_o   (hit),
        .idx_o   (idx),
        .y1_o    (y1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q     <= '0;
            a_q         <= '0;
            pend_v_q    <= 1'b0;
            pend_note_q <= '0;
            drop_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            note_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            count_q     <= count_d;
            a_q         <= a_d;
            pend_v_q    <= pend_v_d;
            pend_note_q <= pend_note_d;
            drop_q      <= drop_d;
            x_q         <= x;
            y_q         <= y;
            x1_q        <= hit ? X_BASE : '0;
            y1_q        <= hit ? y1 : '0;
            note_q      <= hit ? entry_q[idx] : '0;
            valid_q     <= hit;
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign x1_out    = x1_q;
    assign y1_out    = y1_q;
    assign note_out  = note_q;
    assign valid_out = valid_q;
    assign count     = count_q;
    assign dropped   = drop_q;

endmodule

// File: tb/tb_note_history_queue.sv
// Directed and randomized bench for note_history_queue.
// Expected outputs come from a row-list model of the displayed history.
module tb_note_history_queue;

    localparam int D  = 8;
    localparam int XB = 400;
    localparam int YB = 64;
    localparam int P  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        note_in_valid = 1'b0;
    logic [5:0]  note_in = '0;
    logic        clear = 1'b0;
    logic        frame_tick = 1'b0;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic [10:0] x_out, x1_out;
    logic [9:0]  y_out, y1_out;
    logic [5:0]  note_out;
    logic        valid_out;
    logic [4:0]  count;
    logic        dropped;

    int checks = 0;
    int errors = 0;

    int hist [D];
    int m_cnt, m_pv, m_pn, m_a;
    int e_x, e_y, e_x1, e_y1, e_note, e_valid, e_drop;

    note_history_queue dut (
        .clk           (clk),
        .reset         (reset),
        .note_in_valid (note_in_valid),
        .note_in       (note_in),
        .clear         (clear),
        .frame_tick    (frame_tick),
        .x             (x),
        .y             (y),
        .x_out         (x_out),
        .y_out         (y_out),
        .x1_out        (x1_out),
        .y1_out        (y1_out),
        .note_out      (note_out),
        .valid_out     (valid_out),
        .count         (count),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Evaluate the model for the inputs now applied, clock once, compare.
    task automatic cyc();
        int top;
        e_x = int'(x);
        e_y = int'(y);
        e_x1 = 0; e_y1 = 0; e_note = 0; e_valid = 0; e_drop = 0;
        if (reset) begin
            foreach (hist[i]) hist[i] = 0;
            m_cnt = 0; m_pv = 0; m_pn = 0; m_a = 0;
            e_x = 0; e_y = 0;
        end else begin
            for (int k = 0; k < m_cnt; k++) begin
                top = YB + k * P - m_a;
                if (int'(x) >= XB && int'(x) < XB + 32 &&
                    int'(y) >= top && int'(y) < top + P) begin
                    e_valid = 1;
                    e_x1 = XB;
                    e_y1 = top & 1023;
                    e_note = hist[k];
                end
            end
            if (clear) begin
                m_cnt = 0; m_pv = 0; m_a = 0;
            end else begin
                if (frame_tick) begin
                    if (m_pv != 0) begin
                        for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
                        hist[0] = m_pn;
                        m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
                        m_pv = 0;
                        m_a = P;
                    end else if (m_a > 0) begin
                        m_a--;
                    end
                end
                if (note_in_valid) begin
                    e_drop = m_pv;
                    m_pn = int'(note_in);
                    m_pv = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("x_out", 32'(x_out), e_x);
        chk("y_out", 32'(y_out), e_y);
        chk("x1_out", 32'(x1_out), e_x1);
        chk("y1_out", 32'(y1_out), e_y1);
        chk("note_out", 32'(note_out), e_note);
        chk("valid_out", 32'(valid_out), e_valid);
        chk("count", 32'(count), m_cnt);
        chk("dropped", 32'(dropped), e_drop);
    endtask

    task automatic drv(bit nv, int n, bit clr, bit tk, int px, int py);
        note_in_valid = nv;
        note_in = 6'(n);
        clear = clr;
        frame_tick = tk;
        x = 11'(px);
        y = 10'(py);
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(0, 0, 0, 0, 410, 70);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_count", 32'(count), 0);
        drv(0, 0, 0, 0, 410, 70);
        chk("idle_valid", 32'(valid_out), 0);

        drv(1, 13, 0, 0, 0, 0);
        chk("pend_count", 32'(count), 0);
        drv(0, 0, 0, 1, 0, 0);
        chk("commit_count", 32'(count), 1);
        drv(0, 0, 0, 0, 405, 48);
        chk("slide_valid", 32'(valid_out), 1);
        chk("slide_y1", 32'(y1_out), 48);
        chk("slide_x1", 32'(x1_out), 400);
        chk("slide_note", 32'(note_out), 13);
        repeat (16) drv(0, 0, 0, 1, 405, 48);
        drv(0, 0, 0, 0, 405, 64);
        chk("rest_y1", 32'(y1_out), 64);

        do_reset();
        drv(1, 5, 0, 0, 0, 0);
        drv(1, 9, 0, 0, 0, 0);
        chk("drop_pulse", 32'(dropped), 1);
        drv(0, 0, 0, 1, 0, 0);
        chk("drop_count", 32'(count), 1);
        drv(0, 0, 0, 0, 410, 48);
        chk("latest_wins", 32'(note_out), 9);
        drv(0, 0, 0, 0, 410, 64);
        chk("row1_empty", 32'(valid_out), 0);

        do_reset();
        for (int n = 1; n <= 9; n++) begin
            drv(1, n, 0, 0, 0, 0);
            drv(0, 0, 0, 1, 0, 0);
        end
        repeat (16) drv(0, 0, 0, 1, 0, 0);
        chk("full_count", 32'(count), 8);
        drv(0, 0, 0, 0, 400, 176);
        chk("oldest_note", 32'(note_out), 2);
        chk("oldest_y1", 32'(y1_out), 176);
        drv(0, 0, 0, 0, 400, 192);
        chk("below_list", 32'(valid_out), 0);
        drv(0, 0, 0, 0, 399, 64);
        chk("x_left", 32'(valid_out), 0);
        drv(0, 0, 0, 0, 432, 64);
        chk("x_right", 32'(valid_out), 0);
        drv(0, 0, 0, 0, 431, 64);
        chk("x_last", 32'(valid_out), 1);

        drv(1, 7, 1, 0, 0, 0);
        chk("clear_count", 32'(count), 0);
        drv(0, 0, 0, 1, 0, 0);
        chk("clear_pend", 32'(count), 0);

        drv(1, 3, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0);
        repeat (9) drv(0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 405, 57);
        chk("anim_a7", 32'(y1_out), 57);
        reset = 1'b1;
        drv(0, 0, 0, 0, 405, 57);
        reset = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_valid", 32'(valid_out), 0);
        drv(0, 0, 0, 0, 405, 57);
        chk("midrst_after", 32'(valid_out), 0);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            drv($urandom_range(0, 3) == 0, int'($urandom_range(0, 63)),
                $urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                int'($urandom_range(390, 440)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023))
                                            : int'($urandom_range(40, 200)));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_history_queue.md
Name: note_history_queue

Overview:
- Upstream stage of the per-note text renderer.
- Keeps the most recent DEPTH played notes in a vertical list, newest at the top.
- Animates a smooth downward slide, one pixel per video frame, whenever a new note is committed.
- For every scanned pixel it outputs the box origin (x1_out, y1_out), note code and valid that the renderer consumes, plus the delayed pixel coordinates needed for alignment.

Parameters:
- DEPTH, 8, number of displayed history entries (2..16).
- NOTE_WIDTH, 6, note code width; must equal the renderer's note width.
- X_BASE, 11'd400, left edge of every note box.
- Y_BASE, 10'd64, top of row 0 when at rest; must be >= 2**ROW_SHIFT.
- ROW_SHIFT, 4, log2 of the row pitch in pixels (pitch = 16).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- note_in_valid  in  1  one-cycle pulse: new note played.
- note_in  in  NOTE_WIDTH  note code, sampled when note_in_valid=1.
- clear  in  1  one-cycle pulse: empty the history.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- x  in  11  current pixel column.
- y  in  10  current pixel row.
- x_out  out  11  x delayed by 1 cycle.
- y_out  out  10  y delayed by 1 cycle.
- x1_out  out  11  box left edge for (x_out, y_out).
- y1_out  out  10  box top edge for (x_out, y_out).
- note_out  out  NOTE_WIDTH  note code for the box.
- valid_out  out  1  a box covers this pixel row band.
- count  out  5  committed entries, 0..DEPTH.
- dropped  out  1  one-cycle pulse: a pending note was overwritten.

Behaviour:
- The single clock and reset are fixed: port names clk and reset; reset is synchronous and active-high.
- Reset: all entries 0; count=0; pending_valid=0; anim offset a=0.
- Reset: x_out, y_out, x1_out, y1_out, note_out, valid_out and dropped all 0.
- Storage: shift array entry[0..DEPTH-1], where entry[0] is the newest.
- Pending register (pending_valid, pending_note) makes list updates frame-synchronous, so there is no tearing.
- Push (note_in_valid=1, clear=0): pending_note <= note_in and pending_valid <= 1. If pending_valid was already 1, the latest note wins and dropped pulses for 1 cycle.
- clear=1 has highest priority after reset:
  - count <= 0, pending_valid <= 0, a <= 0.
  - note_in_valid in the same cycle is ignored.
  - Entries need not be zeroed.
- frame_tick=1, commit (pending_valid=1):
  - entry[i+1] <= entry[i]; entry[0] <= pending_note; the oldest entry falls off when full.
  - count <= min(count+1, DEPTH); pending_valid <= 0; a <= 2**ROW_SHIFT.
- frame_tick=1 with no pending note: if a>0, a <= a-1.
- frame_tick and push in the same cycle: the commit uses the old pending value, then the new note becomes pending. If no old pending value exists, the new note is only latched.
- Pixel lookup, registered, latency exactly 1 cycle:
  - rel = y + a - Y_BASE, computed at 11 bits.
  - Hit when X_BASE <= x < X_BASE+32, rel >= 0, and (rel >> ROW_SHIFT) < count.
  - idx = rel >> ROW_SHIFT.
  - On hit: x1_out <= X_BASE; y1_out <= Y_BASE + (idx << ROW_SHIFT) - a, truncated to 10 bits; note_out <= entry[idx]; valid_out <= 1.
  - Otherwise: valid_out <= 0 and x1_out, y1_out, note_out <= 0.
  - x_out <= x and y_out <= y every cycle.
- The renderer's own 8-row box check blanks the remaining rows in each 16-pixel pitch.
- The lookup is independent of push/commit timing. Storage changes take effect on the cycle after the tick.
- Reset mid-animation: everything returns to reset values immediately.

Decomposition:
- Shared package (note_display_pkg):
  - NOTE_WIDTH, BOX_W=32, BOX_H=8.
  - Screen coordinate widths (11 for x, 10 for y).
- The renderer and this block must take NOTE_WIDTH from the package.
- One natural sub-module: note_history_lookup, the combinational rel/idx/hit/y1 computation. It is instantiated once and registered in the parent.

Test Plan:
- Reset, then x=410, y=70 -> valid_out=0 one cycle later; count=0; all outputs 0.
- note_in 13, no tick -> count=0. First frame_tick -> count=1 and a=16. Then x=405, y=48 -> next cycle valid_out=1, y1_out=48, x1_out=400, note_out=13. After 16 more ticks, x=405, y=64 -> y1_out=64.
- Push 5, then push 9 before any tick -> dropped pulses on the 9 push. Tick -> count=1, entry[0]=9; row 0 shows 9, row 1 not valid.
- Nine push+tick pairs with notes 1..9, then 16 idle ticks -> count=8. x=400, y=64+7*16=176 -> note_out=2, y1_out=176. y=192 -> valid_out=0.
- Boundary x: with count>=1 at rest, x=399 and x=432 -> valid_out=0; x=431 -> valid_out=1.
- clear with note_in_valid same cycle -> count=0, pending empty; next tick leaves count=0.
- Reset asserted at a=7 -> the next cycle a=0, count=0, valid_out=0.
